// File: rtl/audio_sample_frontend_pkg.sv
// Shared CCHW types for the audio front end: mix mode encoding, read FSM states
// and a clog2 helper that never returns a zero width.
package audio_sample_frontend_pkg;

  typedef enum logic [1:0] {MIX_SUM, MIX_AVG, MIX_SEL, MIX_RSVD} mix_mode_t;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

  localparam int MIN_SEL_W = 1;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : MIN_SEL_W;
  endfunction

endpackage

// File: rtl/audio_sample_frontend_level_meter.sv
// Peak-hold level meter with free-running decay counter and sticky clip flag.
// Only instantiated when AFE_METER_EN is defined.
module level_meter #(
  parameter int IN_W        = 24,
  parameter int METER_W     = 10,
  parameter int DECAY_SHIFT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_vld,
  input  logic signed [IN_W-1:0] i_mix,
  input  logic                   i_sat,
  input  logic                   i_clr,
  output logic [METER_W-1:0]     o_level,
  output logic                   o_clip
);

  localparam logic signed [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0]        MAG_MAX  = {1'b0, {(IN_W-1){1'b1}}};

  logic [IN_W-1:0]        w_abs;
  logic [METER_W-1:0]     w_mag;
  logic                   w_wrap;
  logic [DECAY_SHIFT-1:0] r_decay;
  logic [METER_W-1:0]     r_level;
  logic                   r_clip;

  // The most negative sample has no positive twin, so it pins to full scale.
  always_comb begin
    w_abs = i_mix[IN_W-1] ? IN_W'(-i_mix) : IN_W'(i_mix);
    if (i_mix == MOST_NEG) w_abs = MAG_MAX;
    w_mag  = METER_W'(w_abs >> (IN_W - 1 - METER_W));
    w_wrap = &r_decay;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_decay <= '0;
      r_level <= '0;
      r_clip  <= 1'b0;
    end else begin
      r_decay <= r_decay + 1'b1;
      if (i_vld && (w_mag > r_level)) r_level <= w_mag;
      else if (w_wrap && (r_level != '0)) r_level <= r_level - 1'b1;
      if (i_vld && i_sat) r_clip <= 1'b1;
      else if (i_clr)     r_clip <= 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_clip  = r_clip;

endmodule

// File: rtl/audio_sample_frontend.sv
// Codec read handshake, channel mix, box-car decimation and NoteFinder start pulse.
// Define AFE_METER_EN to build the level meter and sticky clip flag.
module audio_sample_frontend
  import audio_sample_frontend_pkg::*;
#(
  parameter int IN_W        = 24,
  parameter int N           = 16,
  parameter int CH          = 2,
  parameter int DECIM       = 1,
  parameter int START_DELAY = 4,
  parameter int METER_W     = 10,
  parameter int DECAY_SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sampleReady,
  input  logic [CH-1:0][IN_W-1:0]      inSamples,
  input  logic [1:0]                   mode,
  input  logic [clog2_min1(CH)-1:0]    chSel,
  input  logic                         clipClear,
  output logic                         doingRead,
  output logic signed [N-1:0]          sampleOut,
  output logic                         sampleValid,
  output logic                         startCycle,
  output logic [METER_W-1:0]           level,
  output logic                         clip
);

  localparam int CHB  = $clog2(CH);
  localparam int SW   = IN_W + CHB;
  localparam int SELW = clog2_min1(CH);
  localparam int DB   = $clog2(DECIM);
  localparam int DCW  = clog2_min1(DECIM);
  localparam int AW   = IN_W + DB;
  localparam logic signed [IN_W-1:0] MIX_MAX = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIX_MIN = {1'b1, {(IN_W-1){1'b0}}};

  rd_state_t r_state, w_state_nxt;

  logic                   r_vld_p0;
  logic signed [IN_W-1:0] r_smp_p0 [CH];
  mix_mode_t              r_mode_p0;
  logic [SELW-1:0]        r_sel_p0;

  logic signed [SW-1:0]   w_sum;
  logic signed [IN_W-1:0] w_sel;
  logic signed [IN_W-1:0] w_mix;
  logic                   w_sat;

  logic signed [AW-1:0]   r_acc;
  logic signed [AW-1:0]   w_acc_sum;
  logic [DCW-1:0]         r_dcnt;
  logic                   w_last;
  logic                   r_valid;
  logic signed [N-1:0]    r_sample_out;
  logic [START_DELAY-1:0] r_dly;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = RD_IDLE;
    doingRead   = 1'b0;
    case (r_state)
      RD_IDLE: if (sampleReady) w_state_nxt = RD_READ;
      RD_READ: doingRead = 1'b1;
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // p0: capture samples and mix controls in the READ cycle
  always_ff @(posedge clk) begin
    if (rst) r_vld_p0 <= 1'b0;
    else     r_vld_p0 <= doingRead;
  end

  always_ff @(posedge clk) begin
    if (doingRead) begin
      for (int c = 0; c < CH; c++) r_smp_p0[c] <= inSamples[c];
      r_mode_p0 <= mix_mode_t'(mode);
      r_sel_p0  <= chSel;
    end
  end

  always_comb begin
    w_sum = '0;
    w_sel = '0;
    for (int c = 0; c < CH; c++) begin
      w_sum = w_sum + SW'(r_smp_p0[c]);
      if (CH == 1 || SELW'(c) == r_sel_p0) w_sel = r_smp_p0[c];
    end
    w_sat = 1'b0;
    case (r_mode_p0)
      MIX_AVG: w_mix = w_sum[SW-1 -: IN_W];
      MIX_SEL: w_mix = w_sel;
      default: begin
        w_mix = w_sum[IN_W-1:0];
        if (w_sum > SW'(MIX_MAX)) begin
          w_mix = MIX_MAX;
          w_sat = 1'b1;
        end else if (w_sum < SW'(MIX_MIN)) begin
          w_mix = MIX_MIN;
          w_sat = 1'b1;
        end
      end
    endcase
    w_acc_sum = r_acc + AW'(w_mix);
    w_last    = (r_dcnt == DCW'(DECIM - 1));
  end

  // p1: decimation window; the top N bits of acc>>>DB are acc[AW-1 -: N]
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_dcnt       <= '0;
      r_valid      <= 1'b0;
      r_sample_out <= '0;
    end else begin
      r_valid <= 1'b0;
      if (r_vld_p0) begin
        if (w_last) begin
          r_acc        <= '0;
          r_dcnt       <= '0;
          r_valid      <= 1'b1;
          r_sample_out <= w_acc_sum[AW-1 -: N];
        end else begin
          r_acc  <= w_acc_sum;
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_dly <= '0;
    else     r_dly <= (r_dly << 1) | START_DELAY'(r_valid);
  end

  assign sampleOut   = r_sample_out;
  assign sampleValid = r_valid;
  assign startCycle  = r_dly[START_DELAY-1];

`ifdef AFE_METER_EN
  logic                   r_vld_p1;
  logic signed [IN_W-1:0] r_mix_p1;
  logic                   r_sat_p1;

  // p1: registered mix result feeding the meter
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= r_vld_p0;
  end

  always_ff @(posedge clk) begin
    r_mix_p1 <= w_mix;
    r_sat_p1 <= w_sat;
  end

  level_meter #(
    .IN_W        (IN_W),
    .METER_W     (METER_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_meter (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (r_vld_p1),
    .i_mix   (r_mix_p1),
    .i_sat   (r_sat_p1),
    .i_clr   (clipClear),
    .o_level (level),
    .o_clip  (clip)
  );
`else
  logic w_unused_clip_clear;
  assign w_unused_clip_clear = clipClear;
  assign level = '0;
  assign clip  = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_frontend.sv
// Bench for audio_sample_frontend: table-driven mix vectors with a sampleOut scoreboard,
// plus hand-written read-timing, start-pulse, clip, meter and decimation sequences.
module tb_audio_sample_frontend;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, sampleReady, clipClear, chSel;
  logic [1:0][23:0] inSamples;
  logic [1:0]       mode;

  logic        dr, sv, sc, clp;
  logic [15:0] so;
  logic [9:0]  lvl;
  logic        d_dr, d_sv, d_sc, d_clp;
  logic [15:0] d_so;
  logic [9:0]  d_lvl;

  audio_sample_frontend #(.DECAY_SHIFT(2)) u_dut (
    .clk(clk), .rst(rst), .sampleReady(sampleReady), .inSamples(inSamples),
    .mode(mode), .chSel(chSel), .clipClear(clipClear), .doingRead(dr),
    .sampleOut(so), .sampleValid(sv), .startCycle(sc), .level(lvl), .clip(clp)
  );

  audio_sample_frontend #(.DECIM(4), .DECAY_SHIFT(2)) u_dec (
    .clk(clk), .rst(rst), .sampleReady(sampleReady), .inSamples(inSamples),
    .mode(mode), .chSel(chSel), .clipClear(clipClear), .doingRead(d_dr),
    .sampleOut(d_so), .sampleValid(d_sv), .startCycle(d_sc), .level(d_lvl), .clip(d_clp)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic        dec_watch = 1'b0;
  int          dec_cnt = 0;
  logic [15:0] dec_val = '0;

  typedef struct {
    logic [1:0]  m;
    logic        s;
    logic [23:0] l;
    logic [23:0] r;
    logic [15:0] e;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic do_read(input logic [23:0] l, input logic [23:0] r, input logic [1:0] m,
                         input logic s, input logic [15:0] e);
    @(posedge clk); #1;
    inSamples[0] = l; inSamples[1] = r; mode = m; chSel = s;
    sampleReady = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    sampleReady = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (sv) found = 1'b1;
    end
    chk(nm, found, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && sv) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("sampleOut", so, exp_q.pop_front());
    end
    if (dec_watch && d_sv) begin
      dec_cnt++;
      dec_val = d_so;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dr_v, sv_v, sc_v;
    logic [9:0]  l0;
    logic        reached;

    vecs[0]  = '{2'd0, 1'b0, 24'h100000, 24'h100000, 16'h2000};
    vecs[1]  = '{2'd1, 1'b0, 24'h100000, 24'h100000, 16'h1000};
    vecs[2]  = '{2'd2, 1'b1, 24'h123456, 24'h0A0000, 16'h0A00};
    vecs[3]  = '{2'd2, 1'b0, 24'h123456, 24'h0A0000, 16'h1234};
    vecs[4]  = '{2'd0, 1'b0, 24'hF00000, 24'hF00000, 16'hE000};
    vecs[5]  = '{2'd3, 1'b0, 24'h010000, 24'h020000, 16'h0300};
    vecs[6]  = '{2'd1, 1'b0, 24'h000100, 24'hFFFF00, 16'h0000};
    vecs[7]  = '{2'd0, 1'b0, 24'h900000, 24'h900000, 16'h8000};
    vecs[8]  = '{2'd1, 1'b0, 24'h7FFFFF, 24'h7FFFFF, 16'h7FFF};
    vecs[9]  = '{2'd1, 1'b0, 24'h000300, 24'h000000, 16'h0001};
    vecs[10] = '{2'd0, 1'b0, 24'h7FFFFF, 24'h000001, 16'h7FFF};

    rst = 1'b1; sampleReady = 1'b0; clipClear = 1'b0; chSel = 1'b0;
    mode = 2'd0; inSamples = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_doingRead", dr, 0);
    chk("rst_sampleOut", so, 0);
    chk("rst_sampleValid", sv, 0);
    chk("rst_startCycle", sc, 0);
    chk("rst_level", lvl, 0);
    chk("rst_clip", clp, 0);
    chk("rst_dec_sampleOut", d_so, 0);
    chk("rst_dec_sampleValid", d_sv, 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 11; i++) do_read(vecs[i].l, vecs[i].r, vecs[i].m, vecs[i].s, vecs[i].e);
    idle(6);
    chk("table_drain", exp_q.size(), 0);

    // Continuous sampleReady for 10 cycles starting at cycle T (loop index 0).
    inSamples[0] = 24'h010000; inSamples[1] = 24'h010000; mode = 2'd0;
    repeat (5) exp_q.push_back(16'h0200);
    sampleReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); dr_v[i] = dr; sv_v[i] = sv;
      @(posedge clk); #1;
      if (i == 9) sampleReady = 1'b0;
    end
    chk("burst_doingRead", dr_v, 16'h02AA);
    chk("burst_sampleValid", sv_v, 16'h0AA8);
    idle(10);

    // Two reads -> valids at T+3, T+5 -> startCycle at T+7, T+9.
    repeat (2) exp_q.push_back(16'h0200);
    sampleReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); sv_v[i] = sv; sc_v[i] = sc;
      @(posedge clk); #1;
      if (i == 2) sampleReady = 1'b0;
    end
    chk("start_sampleValid", sv_v, 16'h0028);
    chk("start_pulses", sc_v, 16'h0280);

    // Same, but reset during cycle T+6 wipes the in-flight pulses.
    repeat (2) exp_q.push_back(16'h0200);
    sampleReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); sc_v[i] = sc;
      @(posedge clk); #1;
      if (i == 2) sampleReady = 1'b0;
      if (i == 5) rst = 1'b1;
      if (i == 6) rst = 1'b0;
    end
    chk("rst_start_pulses", sc_v, 16'h0000);
    @(negedge clk);
    chk("post_rst_sampleOut", so, 0);
    chk("post_rst_level", lvl, 0);
    chk("post_rst_clip", clp, 0);
    chk("post_rst_doingRead", dr, 0);
    @(posedge clk); #1;

    do_read(24'h700000, 24'h700000, 2'd0, 1'b0, 16'h7FFF);
    idle(4);
`ifdef AFE_METER_EN
    chk("clip_set", clp, 1);
    idle(5);
    chk("clip_sticky", clp, 1);
    clipClear = 1'b1;
    @(posedge clk); #1; clipClear = 1'b0;
    chk("clip_cleared", clp, 0);
    do_read(24'h700000, 24'h700000, 2'd0, 1'b0, 16'h7FFF);
    wait_valid("clip_race_valid");
    clipClear = 1'b1;
    @(posedge clk); #1; clipClear = 1'b0;
    @(negedge clk);
    chk("clip_set_wins", clp, 1);
    @(posedge clk); #1;

    pulse_rst();
    do_read(24'h7FFFFF, 24'h000000, 2'd0, 1'b0, 16'h7FFF);
    wait_valid("meter_valid");
    @(posedge clk); @(negedge clk);
    chk("meter_peak", lvl, 10'h3FF);
    l0 = lvl;
    repeat (4) @(negedge clk);
    chk("meter_decay_step", lvl, l0 - 10'd1);
    reached = 1'b0;
    for (int k = 0; k < 5000 && !reached; k++) begin
      @(negedge clk);
      if (lvl == 10'd0) reached = 1'b1;
    end
    chk("meter_reach_zero", reached, 1);
    repeat (8) @(negedge clk);
    chk("meter_floor", lvl, 0);
    @(posedge clk); #1;
    do_read(24'h800000, 24'h000000, 2'd0, 1'b0, 16'h8000);
    wait_valid("meter_neg_valid");
    @(posedge clk); @(negedge clk);
    chk("meter_most_negative", lvl, 10'h3FF);
    @(posedge clk); #1;
`else
    chk("no_meter_clip", clp, 0);
    chk("no_meter_level", lvl, 0);
`endif

    pulse_rst();
    dec_watch = 1'b1;
    do_read(24'h000400, 24'h000400, 2'd1, 1'b0, 16'h0004);
    do_read(24'h000800, 24'h000800, 2'd1, 1'b0, 16'h0008);
    do_read(24'h000C00, 24'h000C00, 2'd1, 1'b0, 16'h000C);
    do_read(24'h001000, 24'h001000, 2'd1, 1'b0, 16'h0010);
    idle(6);
    chk("decim_count", dec_cnt, 1);
    chk("decim_value", dec_val, 16'h000A);

    // Mode changes inside one window.
    do_read(24'h000400, 24'h000400, 2'd0, 1'b0, 16'h0008);
    do_read(24'h000800, 24'h000800, 2'd1, 1'b0, 16'h0008);
    do_read(24'h000800, 24'h000123, 2'd2, 1'b0, 16'h0008);
    do_read(24'h000400, 24'h000400, 2'd0, 1'b0, 16'h0008);
    idle(6);
    chk("decim_mixed_count", dec_cnt, 2);
    chk("decim_mixed_value", dec_val, 16'h0008);

    // Partial window discarded by reset.
    do_read(24'h7F0000, 24'h7F0000, 2'd1, 1'b0, 16'h7F00);
    do_read(24'h7F0000, 24'h7F0000, 2'd1, 1'b0, 16'h7F00);
    idle(4);
    pulse_rst();
    repeat (4) do_read(24'h000400, 24'h000400, 2'd1, 1'b0, 16'h0004);
    idle(6);
    chk("decim_rst_count", dec_cnt, 3);
    chk("decim_rst_value", dec_val, 16'h0004);

    idle(8);
    chk("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_frontend.md
# audio_sample_frontend

Parametrised front end between the audio codec and the DFT and NoteFinder pipeline. It runs the codec read handshake and captures CH channel samples per read. It mixes the channels (sum, average or select), optionally box-car decimates, and emits N-bit samples with a valid strobe. It also produces a delayed start pulse for NoteFinder and, optionally, a peak-hold level meter with a sticky clip flag.

## Interface
- IN_W, 24, codec sample width (signed)
- N, 16, output sample width; top N bits of the IN_W-bit mix result
- CH, 2, channel count; power of 2, 1..8
- DECIM, 1, decimation factor; power of 2, 1..16
- START_DELAY, 4, cycles from sampleValid to startCycle; 1..16
- METER_W, 10, level meter width
- DECAY_SHIFT, 16, meter decays 1 LSB every 2^DECAY_SHIFT cycles
- clk  in  1  system clock (CLOCK_50); the block uses this one clock only
- rst  in  1  reset; synchronous and active-high
- sampleReady  in  1  codec has a sample pair available
- inSamples  in  CH x IN_W  signed codec samples; valid while sampleReady=1
- mode  in  2  0=SUM, 1=AVG, 2=SEL, 3=reserved (treated as SUM)
- chSel  in  clog2(CH) (min 1)  channel used in SEL mode
- clipClear  in  1  clears the sticky clip flag
- doingRead  out  1  one-cycle codec read strobe
- sampleOut  out  N  signed mixed/decimated sample
- sampleValid  out  1  one-cycle strobe; sampleOut is valid in that cycle
- startCycle  out  1  one-cycle NoteFinder start pulse
- level  out  METER_W  peak-hold magnitude
- clip  out  1  sticky saturation flag

## Operation
- Read FSM has two states, IDLE and READ.
  - IDLE -> READ when sampleReady=1.
  - READ always returns to IDLE.
  - doingRead=1 exactly in READ, so there is at least one idle cycle between reads. A continuously high sampleReady gives doingRead on alternating cycles.
- Capture: inSamples, mode and chSel are registered in the READ cycle.
- Mix arithmetic is signed, using IN_W+clog2(CH) bits.
  - SUM: full sum saturated to IN_W bits; saturation sets clip.
  - AVG: full sum arithmetically shifted right by clog2(CH); never saturates.
  - SEL: inSamples[chSel].
  - The mix result is registered one cycle after capture.
- Decimation:
  - The accumulator (IN_W+clog2(DECIM) bits) sums DECIM mix results.
  - On the DECIM-th result: output = accumulator >>> clog2(DECIM); sampleOut = top N bits of that IN_W result; sampleValid pulses; accumulator restarts with 0.
  - DECIM=1 passes each mix result through.
- Start pulse: a START_DELAY-deep shift register fed by sampleValid drives startCycle. Overlapping pulses in flight are all preserved.
- Meter (feature-gated):
  - |mix result| top METER_W bits; the most negative value maps to the maximum magnitude.
  - If that magnitude > level, level loads it. Otherwise level decrements by 1 on each decay-counter wrap, saturating at 0.
- clip: set by saturation, cleared by clipClear. If clipClear and a saturation occur in the same cycle, set wins.
- mode and chSel changes take effect per sample and do not restart the decimation window.

## Timing
- Reset values: all outputs 0, FSM in IDLE; accumulator, decimation counter, delay line and decay counter all 0.
- Reset during operation discards any partial decimation window and in-flight start pulses. The first read after reset is still handled normally.
- Latency:
  - sampleReady rises at cycle T -> doingRead at T+1 -> mix register valid at T+2 -> sampleValid at T+3 (for the last sample of a window).
  - startCycle = sampleValid + START_DELAY cycles.
- sampleOut holds its value between sampleValid strobes.

## Configuration
- AFE_METER_EN defined: the level meter, decay counter and clip flag are built.
- AFE_METER_EN undefined: level=0 and clip=0 permanently, and no meter logic is built. The sample path is unaffected; saturation still occurs in SUM mode.

## Structure
- CCHW package holds typedef enum logic [1:0] mix_mode_t {MIX_SUM, MIX_AVG, MIX_SEL, MIX_RSVD} and a clog2-safe width helper constant.
- One sub-module, level_meter: peak hold, decay counter and clip flag. It is instantiated under AFE_METER_EN.

## Test plan
- Default parameters, SUM, L=R=0x100000 -> sampleOut=0x2000. AVG with the same inputs -> 0x1000. SEL with chSel=1, R=0x0A0000 -> 0x0A00.
- SUM, L=R=0x700000 -> sampleOut=0x7FFF and clip=1, which persists. A clipClear pulse -> clip=0. clipClear in the same cycle as a saturating sample -> clip stays 1.
- sampleReady held high for 10 cycles from T -> doingRead at T+1, T+3, …, T+9 (5 pulses) and 5 sampleValid strobes, each starting at T+3.
- DECIM=4, AVG, CH=2, sample pairs of 0x000400, 0x000800, 0x000C00, 0x001000 on both channels -> a single sampleValid with sampleOut=0x000A.
- START_DELAY=4: two sampleValid strobes 2 cycles apart -> two startCycle pulses 4 cycles after each. rst asserted between them -> no startCycle, all outputs 0.
- AFE_METER_EN, DECAY_SHIFT=2: a sample of 0x7FFFFF -> level=0x3FF, then a decrement every 4 cycles of silence down to 0. Without the macro -> level=0 throughout.
